// File: rtl/axi_probe_target_if.sv
// axi_probe_target_if: AXI-lite style write (AW/W/B) and read (AR/R) channel bundle
interface axi_probe_target_if;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready, araddr, arsize, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready, araddr, arsize, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_probe_target.sv
// axi_probe_target: AXI-lite responder over a word memory, one write and one read outstanding
module axi_probe_target #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RD_LATENCY = 1
) (
  input logic clk,
  input logic m_aresetn,
  axi_probe_target_if.slave s
);
  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN  = 32'(4) << DEPTH_LOG2;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} r_state_t;

  function automatic logic bad(input logic [31:0] off, input logic [2:0] sz);
    return off >= SPAN || sz > 3'd2 || (sz == 3'd1 && off[0]) || (sz == 3'd2 && off[1:0] != 2'b00);
  endfunction

  logic [31:0] mem [DEPTH];
  logic                  aw_held, w_held;
  logic [31:0]           aw_addr, w_data;
  logic [2:0]            aw_size;
  logic [3:0]            w_strb;
  logic                  aw_fire, w_fire, wr_commit, wr_err;
  logic [31:0]           wa, wd, wr_off, wr_word;
  logic [2:0]            wsz;
  logic [3:0]            wst, wr_be;
  logic [DEPTH_LOG2-1:0] wr_idx;

  assign s.awready = !aw_held && !s.bvalid;
  assign s.wready  = !w_held && !s.bvalid;
  assign aw_fire   = s.awvalid && s.awready;
  assign w_fire    = s.wvalid && s.wready;

  // A channel captured this very cycle is used straight from the bus so AW+W together commit at once
  always_comb begin
    wa        = aw_held ? aw_addr : s.awaddr;
    wsz       = aw_held ? aw_size : s.awsize;
    wd        = w_held ? w_data : s.wdata;
    wst       = w_held ? w_strb : s.wstrb;
    wr_commit = m_aresetn && (aw_held || aw_fire) && (w_held || w_fire);
    wr_off    = wa - BASE_ADDR;
    wr_idx    = wr_off[DEPTH_LOG2+1:2];
    wr_err    = bad(wr_off, wsz);
    wr_be     = wr_err ? 4'b0000 : wsz == 3'd2 ? wst : !(|wst) ? 4'b0000 :
                wsz == 3'd1 ? (wr_off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << wr_off[1:0];
    wr_word   = wsz == 3'd2 ? wd : wsz == 3'd1 ? {2{wd[15:0]}} : {4{wd[7:0]}};
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      aw_size  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      s.bvalid <= 1'b0;
      s.bresp  <= 2'b00;
    end else if (wr_commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      s.bvalid <= 1'b1;
      s.bresp  <= wr_err ? 2'b10 : 2'b00;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= s.awaddr;
        aw_size <= s.awsize;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= s.wdata;
        w_strb <= s.wstrb;
      end
      if (s.bvalid && s.bready) s.bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk)
    if (wr_commit)
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];

  r_state_t              state, next_state;
  logic [3:0]            cnt;
  logic [31:0]           ar_addr, ra, rd_off, rd_word, rd_data;
  logic [2:0]            ar_size, rsz;
  logic [15:0]           rd_half;
  logic [7:0]            rd_byte;
  logic                  rd_err, rd_enter;
  logic [DEPTH_LOG2-1:0] rd_idx;

  always_ff @(posedge clk or negedge m_aresetn)
    if (!m_aresetn) state <= R_IDLE;
    else state <= next_state;

  // cnt holds the remaining wait cycles; leave R_WAIT on the cycle it would reach zero
  always_comb begin
    next_state = state == R_IDLE ? (s.arvalid ? (RD_LATENCY == 1 ? R_VALID : R_WAIT) : R_IDLE) :
                 state == R_WAIT ? (cnt == 4'd1 ? R_VALID : R_WAIT) :
                 (s.rready ? R_IDLE : R_VALID);
  end

  always_comb begin
    s.arready = state == R_IDLE;
    s.rvalid  = state == R_VALID;
  end

  always_comb begin
    ra       = state == R_IDLE ? s.araddr : ar_addr;
    rsz      = state == R_IDLE ? s.arsize : ar_size;
    rd_off   = ra - BASE_ADDR;
    rd_idx   = rd_off[DEPTH_LOG2+1:2];
    rd_err   = bad(rd_off, rsz);
    rd_enter = state != R_VALID && next_state == R_VALID;
    rd_word  = mem[rd_idx];
    for (int i = 0; i < 4; i++)
      if (wr_commit && wr_idx == rd_idx && wr_be[i]) rd_word[8*i +: 8] = wr_word[8*i +: 8];
    rd_half  = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte  = rd_word[{rd_off[1:0], 3'b000} +: 8];
    rd_data  = rd_err ? 32'h0 : rsz == 3'd2 ? rd_word : rsz == 3'd1 ? {2{rd_half}} : {4{rd_byte}};
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      cnt     <= '0;
      ar_addr <= '0;
      ar_size <= '0;
      s.rdata <= '0;
      s.rresp <= 2'b00;
    end else begin
      if (state == R_IDLE && s.arvalid) begin
        ar_addr <= s.araddr;
        ar_size <= s.arsize;
        cnt     <= 4'(RD_LATENCY - 1);
      end else if (state == R_WAIT) cnt <= cnt - 4'd1;
      if (rd_enter) begin
        s.rdata <= rd_data;
        s.rresp <= rd_err ? 2'b10 : 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_axi_probe_target.sv
// tb_axi_probe_target: directed plan scenarios plus randomized traffic against a byte-array model
module tb_axi_probe_target;
  localparam int RD_LAT = 3;
  logic clk = 1'b0;
  logic m_aresetn = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] ref_mem [1024];

  axi_probe_target_if vif();
  axi_probe_target #(.DEPTH_LOG2(8), .BASE_ADDR(32'h0), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .m_aresetn(m_aresetn), .s(vif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [2:0] sz);
    return a >= 32'd1024 || sz > 3'd2 || (a % (32'd1 << sz)) != 32'd0;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input logic [3:0] st);
    int o;
    if (model_err(a, sz)) return 2'b10;
    o = int'(a);
    if (sz == 3'd2) begin
      for (int i = 0; i < 4; i++) if (st[i]) ref_mem[(o & ~3) + i] = d[8*i +: 8];
    end else if (st != 4'b0) begin
      ref_mem[o] = d[7:0];
      if (sz == 3'd1) ref_mem[o + 1] = d[15:8];
    end
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] sz);
    int o;
    if (model_err(a, sz)) return 32'h0;
    o = int'(a);
    if (sz == 3'd2) return {ref_mem[o+3], ref_mem[o+2], ref_mem[o+1], ref_mem[o]};
    if (sz == 3'd1) return {2{ref_mem[o+1], ref_mem[o]}};
    return {4{ref_mem[o]}};
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input logic [3:0] st,
                          input int wdly, input int bdly, output logic [1:0] resp, output int lat);
    int n;
    bit aw_done, w_done, aw_go, w_go;
    vif.awaddr = a; vif.awsize = sz; vif.wdata = d; vif.wstrb = st;
    vif.awvalid = 1'b1; vif.wvalid = (wdly == 0);
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_go = vif.awvalid && vif.awready;
      w_go = vif.wvalid && vif.wready;
      tick;
      n++;
      if (aw_go) begin aw_done = 1; vif.awvalid = 1'b0; end
      if (w_go) begin w_done = 1; vif.wvalid = 1'b0; end
      if (!w_done && n >= wdly) vif.wvalid = 1'b1;
    end
    vif.awvalid = 1'b0; vif.wvalid = 1'b0;
    lat = 1;
    while (!vif.bvalid && lat < 50) begin tick; lat++; end
    if (!vif.bvalid) begin
      tests++; fails++;
      $display("FAIL write_timeout addr %h got no bvalid want bvalid", a);
    end
    repeat (bdly) tick;
    resp = vif.bresp;
    vif.bready = 1'b1;
    tick;
    vif.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input int rdly,
                         output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n;
    vif.araddr = a; vif.arsize = sz; vif.arvalid = 1'b1; n = 0;
    while (!vif.arready && n < 50) begin tick; n++; end
    tick;
    vif.arvalid = 1'b0;
    lat = 1;
    while (!vif.rvalid && lat < 50) begin tick; lat++; end
    if (!vif.rvalid) begin
      tests++; fails++;
      $display("FAIL read_timeout addr %h got no rvalid want rvalid", a);
    end
    repeat (rdly) tick;
    d = vif.rdata; resp = vif.rresp;
    vif.rready = 1'b1;
    tick;
    vif.rready = 1'b0;
  endtask

  task automatic test_reset;
    vif.awaddr = '0; vif.awsize = '0; vif.awvalid = 0; vif.wdata = '0; vif.wstrb = '0; vif.wvalid = 0;
    vif.bready = 0; vif.araddr = '0; vif.arsize = '0; vif.arvalid = 0; vif.rready = 0;
    m_aresetn = 1'b0;
    repeat (3) tick;
    m_aresetn = 1'b1;
    tick;
    tests++;
    if ({vif.awready, vif.wready, vif.arready} !== 3'b111) begin
      fails++; $display("FAIL reset_ready got %b want 111", {vif.awready, vif.wready, vif.arready});
    end
    tests++;
    if ({vif.bvalid, vif.rvalid, vif.bresp, vif.rresp} !== 6'b0) begin
      fails++; $display("FAIL reset_valid_resp got %b want 000000", {vif.bvalid, vif.rvalid, vif.bresp, vif.rresp});
    end
    tests++;
    if (vif.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 00000000", vif.rdata); end
  endtask

  task automatic test_byte_rw;
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(32'h05, 3'd0, 32'h0000_00A5, 4'b0001, 0, 0, resp, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL byte_b_latency got %0d want 1", lat); end
    tests++;
    if (resp !== 2'b00) begin fails++; $display("FAIL byte_bresp got %b want 00", resp); end
    do_read(32'h05, 3'd0, 0, d, resp, lat);
    tests++;
    if (lat !== RD_LAT) begin fails++; $display("FAIL byte_r_latency got %0d want %0d", lat, RD_LAT); end
    tests++;
    if (d !== 32'hA5A5_A5A5) begin fails++; $display("FAIL byte_rdata got %h want a5a5a5a5", d); end
    tests++;
    if (resp !== 2'b00) begin fails++; $display("FAIL byte_rresp got %b want 00", resp); end
  endtask

  task automatic test_w_before_aw;
    logic [1:0] resp; logic [31:0] d; int lat;
    vif.wdata = 32'hDEAD_BEEF; vif.wstrb = 4'hF; vif.wvalid = 1'b1;
    tick;
    vif.wvalid = 1'b0;
    tests++;
    if ({vif.wready, vif.awready} !== 2'b01) begin
      fails++; $display("FAIL w_first_ready got wready,awready=%b want 01", {vif.wready, vif.awready});
    end
    tick; tick;
    vif.awaddr = 32'h10; vif.awsize = 3'd2; vif.awvalid = 1'b1;
    tick;
    vif.awvalid = 1'b0;
    tests++;
    if ({vif.bvalid, vif.bresp} !== 3'b100) begin
      fails++; $display("FAIL w_first_b got bvalid,bresp=%b want 100", {vif.bvalid, vif.bresp});
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({vif.bvalid, vif.bresp, vif.awready, vif.wready} !== 5'b10000) begin
        fails++; $display("FAIL b_backpressure cycle %0d got %b want 10000", i, {vif.bvalid, vif.bresp, vif.awready, vif.wready});
      end
      tick;
    end
    vif.bready = 1'b1;
    tick;
    vif.bready = 1'b0;
    tests++;
    if ({vif.bvalid, vif.awready, vif.wready} !== 3'b011) begin
      fails++; $display("FAIL b_release got bvalid,awready,wready=%b want 011", {vif.bvalid, vif.awready, vif.wready});
    end
    do_read(32'h10, 3'd2, 1, d, resp, lat);
    tests++;
    if ({resp, d} !== {2'b00, 32'hDEAD_BEEF}) begin fails++; $display("FAIL w_first_readback got %b %h want 00 deadbeef", resp, d); end
  endtask

  task automatic test_strobe;
    logic [1:0] resp; logic [31:0] d; int lat;
    logic [31:0] addrs [3] = '{32'h08, 32'h0A, 32'h0A};
    logic [2:0] sizes [3] = '{3'd2, 3'd1, 3'd0};
    logic [31:0] exps [3] = '{32'hFF22_FF44, 32'hFF22_FF22, 32'h2222_2222};
    do_write(32'h08, 3'd2, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
    do_write(32'h08, 3'd2, 32'h1122_3344, 4'b0101, 1, 0, resp, lat);
    tests++;
    if (resp !== 2'b00) begin fails++; $display("FAIL strobe_bresp got %b want 00", resp); end
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], sizes[i], 0, d, resp, lat);
      tests++;
      if ({resp, d} !== {2'b00, exps[i]}) begin
        fails++; $display("FAIL strobe_read%0d got %b %h want 00 %h", i, resp, d, exps[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [1:0] resp; logic [31:0] d; int lat;
    do_write(32'h0, 3'd2, 32'h600D_F00D, 4'hF, 0, 0, resp, lat);
    do_write(32'h400, 3'd2, 32'hBAD0_BAD0, 4'hF, 0, 0, resp, lat);
    tests++;
    if (resp !== 2'b10) begin fails++; $display("FAIL err_range_bresp got %b want 10", resp); end
    do_write(32'h0, 3'd3, 32'hBAD1_BAD1, 4'hF, 0, 0, resp, lat);
    tests++;
    if (resp !== 2'b10) begin fails++; $display("FAIL err_size3_bresp got %b want 10", resp); end
    do_write(32'h1, 3'd1, 32'hBAD2_BAD2, 4'hF, 0, 0, resp, lat);
    tests++;
    if (resp !== 2'b10) begin fails++; $display("FAIL err_misalign_bresp got %b want 10", resp); end
    do_read(32'h0, 3'd2, 0, d, resp, lat);
    tests++;
    if ({resp, d} !== {2'b00, 32'h600D_F00D}) begin fails++; $display("FAIL err_mem_unchanged got %b %h want 00 600df00d", resp, d); end
    do_read(32'h400, 3'd2, 0, d, resp, lat);
    tests++;
    if ({resp, d} !== {2'b10, 32'h0}) begin fails++; $display("FAIL err_range_read got %b %h want 10 00000000", resp, d); end
    do_read(32'h2, 3'd2, 0, d, resp, lat);
    tests++;
    if ({resp, d} !== {2'b10, 32'h0}) begin fails++; $display("FAIL err_misalign_read got %b %h want 10 00000000", resp, d); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] resp; logic [31:0] d; int lat; int n;
    vif.araddr = 32'h08; vif.arsize = 3'd2; vif.arvalid = 1'b1;
    vif.wdata = 32'hBADB_AD00; vif.wstrb = 4'hF; vif.wvalid = 1'b1;
    tick;
    vif.arvalid = 1'b0; vif.wvalid = 1'b0;
    n = 0;
    while (!vif.rvalid && n < 50) begin tick; n++; end
    tests++;
    if (vif.rvalid !== 1'b1) begin fails++; $display("FAIL rst_pre_rvalid got %b want 1", vif.rvalid); end
    #2 m_aresetn = 1'b0;
    #1;
    tests++;
    if ({vif.rvalid, vif.bvalid} !== 2'b00) begin
      fails++; $display("FAIL rst_drop got rvalid,bvalid=%b want 00", {vif.rvalid, vif.bvalid});
    end
    tick; tick;
    #2 m_aresetn = 1'b1;
    tick;
    tests++;
    if ({vif.arready, vif.awready, vif.wready, vif.bvalid, vif.rvalid} !== 5'b11100) begin
      fails++; $display("FAIL rst_release got %b want 11100", {vif.arready, vif.awready, vif.wready, vif.bvalid, vif.rvalid});
    end
    tests++;
    if (vif.rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 00000000", vif.rdata); end
    do_read(32'h08, 3'd2, 0, d, resp, lat);
    tests++;
    if ({resp, d} !== {2'b00, 32'hFF22_FF44}) begin fails++; $display("FAIL rst_reread got %b %h want 00 ff22ff44", resp, d); end
  endtask

  task automatic collide(input logic [31:0] ra, input logic [2:0] rsz, input logic [31:0] wa, input logic [2:0] wsz,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] exp_d);
    vif.araddr = ra; vif.arsize = rsz; vif.arvalid = 1'b1;
    tick;
    vif.arvalid = 1'b0;
    repeat (RD_LAT - 2) tick;
    vif.awaddr = wa; vif.awsize = wsz; vif.wdata = wd; vif.wstrb = ws;
    vif.awvalid = 1'b1; vif.wvalid = 1'b1;
    tick;
    vif.awvalid = 1'b0; vif.wvalid = 1'b0;
    tests++;
    if ({vif.rvalid, vif.bvalid, vif.rresp, vif.rdata} !== {2'b11, 2'b00, exp_d}) begin
      fails++; $display("FAIL collision addr %h got rvalid,bvalid=%b rresp %b rdata %h want 11 00 %h",
                        ra, {vif.rvalid, vif.bvalid}, vif.rresp, vif.rdata, exp_d);
    end
    vif.bready = 1'b1; vif.rready = 1'b1;
    tick;
    vif.bready = 1'b0; vif.rready = 1'b0;
  endtask

  task automatic test_collision;
    logic [1:0] resp; logic [31:0] d; int lat;
    collide(32'h08, 3'd2, 32'h08, 3'd2, 32'h1234_ABCD, 4'b0011, 32'hFF22_ABCD);
    collide(32'h0B, 3'd0, 32'h0B, 3'd0, 32'h0000_005A, 4'b0001, 32'h5A5A_5A5A);
    do_read(32'h08, 3'd2, 0, d, resp, lat);
    tests++;
    if ({resp, d} !== {2'b00, 32'h5A22_ABCD}) begin fails++; $display("FAIL collision_commit got %b %h want 00 5a22abcd", resp, d); end
  endtask

  task automatic test_random;
    logic [1:0] resp, exp_r; logic [31:0] d, exp_d, a; logic [2:0] sz; logic [3:0] st; int lat;
    for (int w = 0; w < 256; w++) begin
      d = $urandom;
      exp_r = model_write(32'(w * 4), 3'd2, d, 4'hF);
      do_write(32'(w * 4), 3'd2, d, 4'hF, 0, 0, resp, lat);
    end
    for (int k = 0; k < 200; k++) begin
      sz = 3'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 1039));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        st = 4'($urandom_range(0, 15));
        exp_r = model_write(a, sz, d, st);
        do_write(a, sz, d, st, $urandom_range(0, 2), $urandom_range(0, 2), resp, lat);
        tests++;
        if ({resp, lat[3:0]} !== {exp_r, 4'd1}) begin
          fails++; $display("FAIL rand_write a %h sz %0d got bresp %b lat %0d want %b 1", a, sz, resp, lat, exp_r);
        end
      end else begin
        exp_d = model_read(a, sz);
        exp_r = model_err(a, sz) ? 2'b10 : 2'b00;
        do_read(a, sz, $urandom_range(0, 2), d, resp, lat);
        tests++;
        if ({resp, d, lat[3:0]} !== {exp_r, exp_d, 4'(RD_LAT)}) begin
          fails++; $display("FAIL rand_read a %h sz %0d got %b %h lat %0d want %b %h %0d", a, sz, resp, d, lat, exp_r, exp_d, RD_LAT);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_byte_rw;
    test_w_before_aw;
    test_strobe;
    test_errors;
    test_reset_mid;
    test_collision;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_probe_target.md
Name: axi_probe_target

Overview:
- Byte-addressable AXI-lite-style responder (slave) backed by a word-organised on-chip memory.
- Forms the far end of the probe's AXI master port, so a UART host can read and write real storage through the probe.
- Also serves as the bench target for probe bring-up.
- Accepts AW/W/B and AR/R transactions, one outstanding write and one outstanding read, with programmable read latency and error responses.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (256 words = 1 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- RD_LATENCY, 1, cycles from AR acceptance to RVALID rising; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- m_aresetn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  32  write byte address.
- s_axi_awsize  in  3  write size (0=byte, 1=half, 2=word).
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR).
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready; may be combinationally tied to bvalid by the master.
- s_axi_araddr  in  32  read byte address.
- s_axi_arsize  in  3  read size.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready; may be combinationally tied to rvalid.

Behaviour:
- Reset (async assert, sync release):
  - awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=00; rdata=0.
  - All held address/data/state cleared.
  - Memory array is NOT reset; contents survive reset.
- Address decode:
  - off = addr - BASE_ADDR (32-bit wrap).
  - In range iff off < 4<<DEPTH_LOG2; word index = off[DEPTH_LOG2+1:2].
  - Error if out of range, size>2, or addr not aligned to 1<<size.
- Write channel (independent AW and W capture, any order, same cycle allowed):
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW handshake latches addr/size; W handshake latches data/strb.
  - Edge after both are held: commit the write and assert bvalid with bresp; clear both held flags.
  - AW+W in the same cycle gives bvalid exactly 1 cycle later.
  - Size 2: byte lane i is written iff wstrb[i].
  - Size 0: wdata[7:0] is written to byte off[1:0] iff |wstrb.
  - Size 1: wdata[15:0] is written to halfword off[1] iff |wstrb.
  - Error: no memory update; bresp=10.
  - bvalid and bresp are held until bready. On the bready&&bvalid edge, bvalid=0 and awready/wready return to 1 on the next cycle.
- Read FSM, states R_IDLE -> R_WAIT -> R_VALID:
  - R_IDLE: arready=1; on arvalid, latch addr/size and load counter with RD_LATENCY-1.
  - From R_IDLE: go to R_VALID if RD_LATENCY==1, else go to R_WAIT.
  - R_WAIT: counter decrements; at 0, go to R_VALID. arready=0.
  - R_VALID: rvalid=1, rdata/rresp stable until rready; then return to R_IDLE.
  - Minimum read period is RD_LATENCY+1 cycles.
- Read data:
  - rdata is captured on the edge entering R_VALID.
  - Size 2: full word.
  - Size 1: addressed halfword replicated in both halves.
  - Size 0: addressed byte replicated in all four lanes.
  - Error: rdata=0, rresp=10.
- Read/write collision: a write committing on the same edge that rdata is captured, to the same word, must be visible in rdata (bypass with strobe merge).
- Reads and writes proceed concurrently; there is no ordering between channels beyond the collision rule.
- Reset mid-transaction: pending B/R are dropped without a response; any partially held AW/W is discarded.

Test Plan:
- Reset release -> awready=wready=arready=1, bvalid=rvalid=0, rdata=0.
- Byte write followed by byte read:
  - AW 0x05 size0 and W 0x000000A5 strb 0001 in the same cycle -> bvalid next cycle, bresp 00.
  - AR 0x05 size0 (RD_LATENCY=3) -> rvalid 3 cycles after AR, rdata 0xA5A5A5A5, rresp 00.
- W before AW with B backpressure:
  - W 0xDEADBEEF strb 1111 three cycles before AW 0x10 size2 -> wready=0 after W while awready stays 1; bvalid one cycle after AW.
  - bready low for 4 cycles -> bvalid and bresp held; awready and wready stay 0 throughout.
- Strobed word write: 0xFFFFFFFF at 0x08, then 0x11223344 strb 0101 at 0x08 -> read of 0x08 size2 returns 0xFF22FF44.
- Error responses (DEPTH_LOG2=8, BASE 0):
  - Write to 0x400 -> bresp 10, memory unchanged.
  - Read 0x400 -> rdata 0, rresp 10.
  - Size2 read at 0x02 -> rresp 10.
  - Size3 write -> bresp 10.
- Reset and collision:
  - m_aresetn low while rvalid=1 -> rvalid drops immediately; after release, arready=1, and a re-read of 0x08 returns 0xFF22FF44.
  - Write to 0x08 committing on the R_VALID entry edge -> new data returned.
